// File: rtl/fft_mag_buffer.sv
// fft_mag_buffer: complex FFT bins -> 16-bit magnitude estimate, written into
// the back bank of a double-buffered bin RAM. The display reads the front bank.
// Banks swap only on frame_sync once a complete frame has fully retired,
// so the display never shows a torn spectrum.
// Optional: define PEAK_DETECT_EN to track the strongest bin of each frame.
module fft_mag_buffer #(
  parameter int NFFT   = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [31:0]       s_tdata,
  input  logic              s_tlast,
  input  logic              frame_sync,
  input  logic [ADDR_W-1:0] vaddr,
  output logic [15:0]       vdata,
  output logic              bank_sel,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [15:0]       peak_mag
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NFFT - 1);
  localparam int STG = 2;

  typedef enum logic {FILL = 1'b0, RESYNC = 1'b1} st_t;

  st_t               st, st_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              wr_frame, wr_frame_nxt;
  logic              swap_pending;
  logic              acc, last_bin;
  logic              wr_beat, frame_ok, frame_drop, frame_err;
  logic              swap, bank_nxt;

  logic [STG-1:0]    vld_pipe;
  logic [14:0]       s1_a, s1_b, s2_mx, s2_mn;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  logic [15:0]       mag;

  logic [15:0]       mem [0:1][0:NFFT-1];

  // |v| clamped to 15 bits; -32768 has no positive twin, so it saturates
  function automatic logic [14:0] sat_abs(input logic [15:0] v);
    logic [15:0] n;
    n = -v;
    if (v == 16'h8000) return 15'h7fff;
    else if (v[15])    return n[14:0];
    else               return v[14:0];
  endfunction

  assign acc      = s_tvalid & s_tready;
  assign last_bin = (cnt == LAST);
  // a bank swap needs a finished frame and no write still in flight
  assign swap     = frame_sync & swap_pending & ~(|vld_pipe);
  assign bank_nxt = swap ? ~bank_sel : bank_sel;

  // write FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= FILL;
    else       st <= st_nxt;
  end

  // write FSM next state
  always_comb begin
    st_nxt = st;
    if (acc) begin
      case (st)
        FILL:    if (last_bin && !s_tlast) st_nxt = RESYNC;
        RESYNC:  if (s_tlast) st_nxt = FILL;
        default: st_nxt = FILL;
      endcase
    end
  end

  // write FSM outputs: write gate, counter, frame events.
  // The write decision is made at bin 0 and held for the whole frame, so a
  // frame that started while a swap was pending stays unwritten to its end.
  always_comb begin
    wr_beat      = 1'b0;
    cnt_nxt      = cnt;
    wr_frame_nxt = wr_frame;
    frame_ok     = 1'b0;
    frame_drop   = 1'b0;
    frame_err    = 1'b0;
    if (acc) begin
      case (st)
        FILL: begin
          wr_beat      = (cnt == '0) ? ~swap_pending : wr_frame;
          wr_frame_nxt = wr_beat;
          cnt_nxt      = last_bin ? '0 : cnt + 1'b1;
          if (s_tlast && !last_bin) begin
            frame_err = 1'b1;
            cnt_nxt   = '0;
          end else if (last_bin && !s_tlast) begin
            frame_err = 1'b1;
          end else if (last_bin) begin
            frame_ok   = wr_beat;
            frame_drop = ~wr_beat;
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  // control registers: counter, swap handshake, bank select, stats
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_tready     <= 1'b0;
      cnt          <= '0;
      wr_frame     <= 1'b0;
      swap_pending <= 1'b0;
      bank_sel     <= 1'b0;
      drop_cnt     <= 8'd0;
      err_cnt      <= 8'd0;
    end else begin
      s_tready <= 1'b1;
      cnt      <= cnt_nxt;
      wr_frame <= wr_frame_nxt;
      bank_sel <= bank_nxt;
      if (swap)     swap_pending <= 1'b0;
      if (frame_ok) swap_pending <= 1'b1;
      if (frame_drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (frame_err  && err_cnt  != 8'hff) err_cnt  <= err_cnt + 8'd1;
    end
  end

  // magnitude pipeline S1 (abs) and S2 (max/min); S3 is the RAM write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_addr  <= '0;
      s2_mx    <= '0;
      s2_mn    <= '0;
      s2_addr  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STG-2:0], wr_beat};
      s1_a     <= sat_abs(s_tdata[15:0]);
      s1_b     <= sat_abs(s_tdata[31:16]);
      s1_addr  <= cnt;
      s2_mx    <= (s1_a > s1_b) ? s1_a : s1_b;
      s2_mn    <= (s1_a > s1_b) ? s1_b : s1_a;
      s2_addr  <= s1_addr;
    end
  end

  // alpha-max-beta-min with beta = 3/8; peaks at 45053, fits 16 bits
  assign mag = {1'b0, s2_mx} + {3'b0, s2_mn[14:2]} + {4'b0, s2_mn[14:3]};

  // S3: back-bank write
  always_ff @(posedge clk) begin
    if (vld_pipe[STG-1]) mem[~bank_sel][s2_addr] <= mag;
  end

  // display read; a swap this cycle already steers the read to the new bank
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vdata <= 16'd0;
    else       vdata <= mem[bank_nxt][vaddr];
  end

`ifdef PEAK_DETECT_EN
  logic [ADDR_W-1:0] pk_bin_r;
  logic [15:0]       pk_mag_r;

  // running peak of the frame being written; bin 0 restarts it, strict >
  // keeps the lowest bin on ties; published and cleared at swap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pk_bin_r <= '0;
      pk_mag_r <= '0;
      peak_bin <= '0;
      peak_mag <= '0;
    end else begin
      if (vld_pipe[STG-1] && (s2_addr == '0 || mag > pk_mag_r)) begin
        pk_bin_r <= s2_addr;
        pk_mag_r <= mag;
      end
      if (swap) begin
        peak_bin <= pk_bin_r;
        peak_mag <= pk_mag_r;
        pk_bin_r <= '0;
        pk_mag_r <= '0;
      end
    end
  end
`else
  assign peak_bin = '0;
  assign peak_mag = '0;
`endif

endmodule

// File: doc/fft_mag_buffer.md
Name: fft_mag_buffer

Overview:
- Sits between the FFT core's output stream and the histogram display renderer.
- Converts each complex FFT bin to a 16-bit magnitude estimate and writes it into one bank of a double-buffered bin RAM.
- The display reads the other bank through a synchronous read port.
- Banks swap only at a display frame boundary, so the histogram never shows a partially updated (torn) spectrum.

Parameters:
- NFFT, 1024, bins per frame; must be a power of 2 and no more than 2^ADDR_W.
- ADDR_W, 10, bin address width; equals the display-side vaddr width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- s_tvalid  in  1  FFT output beat valid
- s_tready  out  1  beat accept
- s_tdata  in  32  [31:16] imag, [15:0] real; both two's complement
- s_tlast  in  1  last bin of FFT frame
- frame_sync  in  1  one-cycle pulse at start of display vertical blank
- vaddr  in  ADDR_W  display read address
- vdata  out  16  magnitude at vaddr, registered
- bank_sel  out  1  bank currently readable by display
- drop_cnt  out  8  frames discarded, saturating
- err_cnt  out  8  malformed frames, saturating
- peak_bin  out  ADDR_W  strongest bin of displayed frame (PEAK_DETECT_EN)
- peak_mag  out  16  its magnitude (PEAK_DETECT_EN)

Behaviour:
- Reset values: s_tready=0, vdata=0, bank_sel=0, drop_cnt=0, err_cnt=0, peak_bin=0, peak_mag=0. Internal state: bin counter=0, state=FILL, swap_pending=0.
- s_tready rises on the first clk edge after rstn deasserts, then stays high. A beat is accepted when s_tvalid and s_tready are both high; the block never back-pressures.
- Magnitude pipeline, 3 stages; a beat accepted at cycle N is written to RAM at cycle N+3:
  - S1: a = |re|, b = |im|, each saturated so that -32768 becomes 32767 (15-bit unsigned result).
  - S2: mx = max(a,b), mn = min(a,b).
  - S3: mag = mx + (mn>>2) + (mn>>3), 16-bit unsigned. Maximum 32767+8191+4095 = 45053, so no overflow is possible.
- Write address is the bin counter, captured with the beat and carried down the pipeline. The write bank is ~bank_sel.
- Write state machine:
  - FILL: accepted beats are written. The counter increments and wraps to 0 after NFFT-1.
    - Beat at counter=NFFT-1 with tlast=1: frame complete. Set swap_pending=1 and latch the write-enable gate.
    - tlast=1 at counter<NFFT-1: err_cnt++; frame abandoned, no swap; counter=0; stay in FILL.
    - Counter=NFFT-1 with tlast=0: err_cnt++; go to RESYNC.
  - RESYNC: beats accepted but not written. The beat with tlast=1 returns the block to FILL with counter=0.
  - While swap_pending=1: incoming beats are accepted but RAM writes are suppressed. When such a frame's tlast arrives, drop_cnt++.
- Swap: on frame_sync with swap_pending=1, and only after the last write of the frame has retired from S3, bank_sel toggles and swap_pending clears. frame_sync with swap_pending=0 does nothing. Writes resume at the next frame start.
- Simultaneous events: a frame_sync in the same cycle the completing beat is accepted does not swap (the write has not retired). The swap happens on the next frame_sync.
- Read port: vdata <= RAM[bank_sel][vaddr] each clk, 1-cycle latency. A bank_sel change takes effect for reads issued the same cycle it toggles.
- Counters saturate at 255.
- Reset mid-frame: all state clears and the partial frame is lost. RAM contents are not cleared and may be stale.

Optional Feature:
- Macro: PEAK_DETECT_EN.
- With the macro defined: S3 tracks the running max mag and its bin during FILL writes. Ties keep the lowest bin. At swap, peak_bin and peak_mag load the tracked values of the newly displayed frame, and the tracker resets to 0.
- Without the macro: no tracker logic; peak_bin and peak_mag are tied to 0.

Test Plan:
- Reset, then one frame with bin k carrying re=k, im=0 and tlast on bin 1023, then a frame_sync pulse -> bank_sel=1; reading vaddr=5 returns vdata=5 one cycle later; drop_cnt=0.
- Beat re=-32768, im=-32768 at bin 0 -> vdata at addr 0 = 45053 after the swap.
- Beat re=300, im=-800 -> mag = 800+75+37 = 912; the RAM write is seen 3 cycles after acceptance.
- Two complete frames with no frame_sync between them, then frame_sync -> drop_cnt=1; the displayed data is from frame 1.
- tlast at bin 500 -> err_cnt=1, no swap on frame_sync. The next 1024-beat frame displays normally.
- PEAK_DETECT_EN defined, frame all zeros except bin 77=0x4000 -> after swap, peak_bin=77, peak_mag=0x4000. Macro undefined -> both outputs 0.
